// File: rtl/hit_stamper_if.sv
// hit_stamper_if
//   Readout bus of the hit stamper. The stamper (master) presents one
//   {timestamp, width, saturation} record at a time. The readout (slave)
//   takes it with a valid/ready handshake.
//
//   oValid  master->slave  record on oTs/oWidth/oSat is valid
//   oTs     master->slave  coarse count sampled on the rising edge (CNT_W bits)
//   oWidth  master->slave  pulse width in clock cycles, saturated (WID_W bits)
//   oSat    master->slave  width field saturated
//   iReady  slave->master  readout accepts the presented record this cycle
interface hit_stamper_if #(
  parameter int CNT_W = 32,
  parameter int WID_W = 16
);
  logic             oValid;
  logic [CNT_W-1:0] oTs;
  logic [WID_W-1:0] oWidth;
  logic             oSat;
  logic             iReady;

  modport master (output oValid, oTs, oWidth, oSat, input iReady);
  modport slave  (input oValid, oTs, oWidth, oSat, output iReady);
endinterface

// File: rtl/hit_stamper.sv
// hit_stamper
//   This block sits after the rise/fall edge detectors in the TDC front end.
//   It tags each hit with a free-running coarse count and measures the pulse
//   width from rise to fall in clock cycles. Each finished record goes into a
//   small first-word fall-through FIFO. The FIFO presents records on the
//   readout interface.
//
//   iClk    system clock (same clock as the edge detectors)
//   iRst_n  asynchronous active-low reset
//   iEn     capture enable; low drops edges and returns the FSM to IDLE
//   iRise   single-cycle rising-edge pulse
//   iFall   single-cycle falling-edge pulse
//   iClr    synchronous clear of oOvf / oDrop
//   rd      readout bus (hit_stamper_if.master)
//   oBusy   rise seen, fall still pending
//   oOvf    sticky flag: a record was lost because the FIFO was full
//   oDrop   lost-record count, saturates at 255
module hit_stamper #(
  parameter int CNT_W = 32,
  parameter int WID_W = 16,
  parameter int DEPTH = 8
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iEn,
  input  logic          iRise,
  input  logic          iFall,
  input  logic          iClr,
  hit_stamper_if.master rd,
  output logic          oBusy,
  output logic          oOvf,
  output logic [7:0]    oDrop
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = CNT_W + WID_W + 1;
  localparam logic [WID_W-1:0] WMAX    = '1;
  localparam logic [AW:0]      PTR_ONE = 1;

  typedef enum logic {IDLE, ARMED} stateT;

  stateT            state;
  stateT            stateNext;
  logic [CNT_W-1:0] coarseCnt;
  logic [CNT_W-1:0] tsReg;
  logic [WID_W-1:0] widReg;
  logic [WID_W-1:0] widPlus;
  logic             satNow;
  logic             armLoad;
  logic             stageLoad;
  logic             stageValid;
  logic [REC_W-1:0] stageRec;
  logic [REC_W-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             pop;
  logic             push;
  logic             dropEv;
  logic [REC_W-1:0] headRec;

  // Free-running coarse counter. It wraps naturally modulo 2^CNT_W.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) coarseCnt <= '0;
    else         coarseCnt <= coarseCnt + CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state logic. A rise while ARMED re-arms. The same holds when rise
  // and fall come together: the fall closes the old pulse and the rise
  // starts a new one.
  always_comb begin
    stateNext = state;
    if (!iEn) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (iRise) stateNext = ARMED;
        ARMED:   if (iRise) stateNext = ARMED;
                 else if (iFall) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // FSM outputs and capture strobes.
  always_comb begin
    oBusy     = (state == ARMED);
    armLoad   = iEn & iRise;
    stageLoad = iEn & iFall & (state == ARMED);
  end

  // widReg holds (cycles since rise - 1). The fall cycle therefore reports
  // widReg+1, which is exactly fall cycle minus rise cycle. widReg stops at
  // WMAX, and any result of WMAX or more is flagged as saturated.
  assign widPlus = (widReg == WMAX) ? WMAX : widReg + WID_W'(1);
  assign satNow  = (widPlus == WMAX);

  // Capture registers for the pulse that is in flight.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      tsReg  <= '0;
      widReg <= '0;
    end else if (armLoad) begin
      tsReg  <= coarseCnt;
      widReg <= '0;
    end else if (state == ARMED && widReg != WMAX) begin
      widReg <= widReg + WID_W'(1);
    end
  end

  // One-deep stage register between the FSM and the FIFO.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stageValid <= 1'b0;
      stageRec   <= '0;
    end else begin
      stageValid <= stageLoad;
      if (stageLoad) stageRec <= {tsReg, widPlus, satNow};
    end
  end

  // The pointers carry an extra wrap bit so that full and empty can be told apart.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop       = !fifoEmpty && rd.iReady;
  assign push      = stageValid && (!fifoFull || pop);
  assign dropEv    = stageValid && fifoFull && !pop;

  // FIFO pointers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // FIFO storage. It needs no reset because the pointers decide what is visible.
  // When full with a pop, the write lands in the slot being read out this cycle.
  always_ff @(posedge iClk) begin
    if (push) mem[wrPtr[AW-1:0]] <= stageRec;
  end

  // Fall-through head. The data is forced to zero while empty so that stale
  // storage never shows up on the bus (for example, straight after reset).
  always_comb begin
    headRec   = mem[rdPtr[AW-1:0]];
    rd.oValid = !fifoEmpty;
    {rd.oTs, rd.oWidth, rd.oSat} = fifoEmpty ? '0 : headRec;
  end

  // Overflow flag and drop counter. A drop in the same cycle as a clear
  // still counts, so the clear leaves a count of exactly one.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oOvf  <= 1'b0;
      oDrop <= '0;
    end else if (iClr) begin
      oOvf  <= dropEv;
      oDrop <= dropEv ? 8'd1 : 8'd0;
    end else if (dropEv) begin
      oOvf <= 1'b1;
      if (oDrop != 8'hFF) oDrop <= oDrop + 8'd1;
    end
  end

endmodule

// File: tb/tb_hit_stamper.sv
// tb_hit_stamper
//   Self-checking bench for hit_stamper (CNT_W=8, WID_W=4, DEPTH=4). Every
//   cycle is compared against a record-level reference model. There is also
//   a table of hand-derived vectors, plus directed sequences for wrap,
//   saturation, overflow, clear and reset.
module tb_hit_stamper;

  localparam int CNT_W = 8;
  localparam int WID_W = 4;
  localparam int DEPTH = 4;
  localparam int WMAX  = 15;

  logic       iClk   = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iEn    = 1'b0;
  logic       iRise  = 1'b0;
  logic       iFall  = 1'b0;
  logic       iClr   = 1'b0;
  logic       oBusy;
  logic       oOvf;
  logic [7:0] oDrop;

  hit_stamper_if #(.CNT_W(CNT_W), .WID_W(WID_W)) rd ();

  hit_stamper #(.CNT_W(CNT_W), .WID_W(WID_W), .DEPTH(DEPTH)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iEn    (iEn),
    .iRise  (iRise),
    .iFall  (iFall),
    .iClr   (iClr),
    .rd     (rd),
    .oBusy  (oBusy),
    .oOvf   (oOvf),
    .oDrop  (oDrop)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic       valid;
    logic [7:0] ts;
    logic [3:0] width;
    logic       sat;
    logic       busy;
    logic       ovf;
    logic [7:0] drop;
  } outT;

  typedef struct {
    logic en, rise, fall, clr, ready;
    outT  exp;
  } vecT;

  typedef struct {
    int ts;
    int width;
    bit sat;
  } recT;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: absolute cycle numbers and a queue of finished records.
  int  cyc      = 0;
  bit  armed    = 0;
  int  riseCyc  = 0;
  bit  stgValid = 0;
  recT stg;
  recT q[$];
  bit  mOvf     = 0;
  int  mDrop    = 0;

  task automatic modelReset();
    cyc = 0; armed = 0; riseCyc = 0; stgValid = 0;
    q.delete(); mOvf = 0; mDrop = 0;
  endtask

  // The head is read out, and then the finished record from the previous
  // cycle lands in the FIFO or is lost. After that, this cycle's edges are
  // applied.
  task automatic modelUpdate(input bit en, input bit rise, input bit fall,
                             input bit clr, input bit ready);
    bit dropped;
    int len;
    dropped = 0;
    if (q.size() > 0 && ready) q.delete(0);
    if (stgValid) begin
      if (q.size() < DEPTH) q.push_back(stg);
      else dropped = 1;
    end
    if (clr) begin
      mOvf  = dropped;
      mDrop = dropped ? 1 : 0;
    end else if (dropped) begin
      mOvf = 1;
      if (mDrop < 255) mDrop++;
    end
    stgValid = 0;
    if (en && armed && fall) begin
      len       = cyc - riseCyc;
      stgValid  = 1;
      stg.ts    = riseCyc % 256;
      stg.width = (len >= WMAX) ? WMAX : len;
      stg.sat   = (len >= WMAX);
    end
    if (!en) armed = 0;
    else if (rise) begin armed = 1; riseCyc = cyc; end
    else if (fall) armed = 0;
    cyc++;
  endtask

  task automatic modelExp(output outT e);
    e.valid = (q.size() > 0);
    e.ts    = e.valid ? 8'(q[0].ts) : 8'd0;
    e.width = e.valid ? 4'(q[0].width) : 4'd0;
    e.sat   = e.valid ? q[0].sat : 1'b0;
    e.busy  = armed;
    e.ovf   = mOvf;
    e.drop  = 8'(mDrop);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input outT e, input string tag);
    cmp({tag, ".valid"}, 32'(rd.oValid), 32'(e.valid));
    cmp({tag, ".ts"},    32'(rd.oTs),    32'(e.ts));
    cmp({tag, ".width"}, 32'(rd.oWidth), 32'(e.width));
    cmp({tag, ".sat"},   32'(rd.oSat),   32'(e.sat));
    cmp({tag, ".busy"},  32'(oBusy),     32'(e.busy));
    cmp({tag, ".ovf"},   32'(oOvf),      32'(e.ovf));
    cmp({tag, ".drop"},  32'(oDrop),     32'(e.drop));
  endtask

  // Inputs are driven at a falling edge. The model advances on the rising
  // edge, and the DUT is checked against it at the next falling edge.
  task automatic applyStimulus(input bit en, input bit rise, input bit fall,
                               input bit clr, input bit ready);
    outT e;
    iEn = en; iRise = rise; iFall = fall; iClr = clr; rd.iReady = ready;
    @(posedge iClk);
    modelUpdate(en, rise, fall, clr, ready);
    @(negedge iClk);
    modelExp(e);
    checkOutput(e, "model");
  endtask

  task automatic idle(input bit ready);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, ready);
  endtask

  // A pulse of exactly len cycles from rise to fall. Returns the expected timestamp.
  task automatic pulse(input int len, input bit ready, output int ts);
    ts = cyc % 256;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, ready);
    repeat (len - 1) idle(ready);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, ready);
  endtask

  function automatic vecT mkVec(bit en, bit rise, bit fall, bit ready,
                                bit v, int ts, int w, bit busy);
    vecT t;
    t.en = en; t.rise = rise; t.fall = fall; t.clr = 1'b0; t.ready = ready;
    t.exp.valid = v;      t.exp.ts  = 8'(ts); t.exp.width = 4'(w);
    t.exp.sat   = 1'b0;   t.exp.busy = busy;  t.exp.ovf = 1'b0; t.exp.drop = 8'd0;
    return t;
  endfunction

  vecT tbl [8];
  outT zeroOut;
  int  tsv;
  int  tsList [5];
  bit  rEn, rRise, rFall, rClr, rReady;

  initial begin
    rd.iReady = 1'b0;
    zeroOut = '{1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0};

    // The table covers the first pulse: rise at count 10, fall five cycles later.
    tbl[0] = mkVec(1, 1, 0, 1, 0, 0, 0, 1);
    tbl[1] = mkVec(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[2] = mkVec(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[3] = mkVec(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[4] = mkVec(1, 0, 0, 1, 0, 0, 0, 1);
    tbl[5] = mkVec(1, 0, 1, 1, 0, 0, 0, 0);
    tbl[6] = mkVec(1, 0, 0, 1, 1, 10, 5, 0);
    tbl[7] = mkVec(1, 0, 0, 1, 0, 0, 0, 0);

    repeat (3) @(negedge iClk);
    checkOutput(zeroOut, "reset");
    iRst_n = 1'b1;
    modelReset();

    repeat (10) idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].en, tbl[i].rise, tbl[i].fall, tbl[i].clr, tbl[i].ready);
      checkOutput(tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Width saturation: 20, 14 and 15 cycle pulses.
    pulse(20, 1'b0, tsv);
    idle(1'b0);
    cmp("sat20.valid", 32'(rd.oValid), 1); cmp("sat20.ts", 32'(rd.oTs), 32'(tsv));
    cmp("sat20.width", 32'(rd.oWidth), 15); cmp("sat20.sat", 32'(rd.oSat), 1);
    idle(1'b0);
    cmp("hold.ts", 32'(rd.oTs), 32'(tsv)); cmp("hold.width", 32'(rd.oWidth), 15);
    idle(1'b1);
    pulse(14, 1'b0, tsv);
    idle(1'b0);
    cmp("w14.width", 32'(rd.oWidth), 14); cmp("w14.sat", 32'(rd.oSat), 0);
    idle(1'b1);
    pulse(15, 1'b0, tsv);
    idle(1'b0);
    cmp("w15.width", 32'(rd.oWidth), 15); cmp("w15.sat", 32'(rd.oSat), 1);
    idle(1'b1);

    // Overflow: five records into a four-deep FIFO, then drain them in order.
    for (int i = 0; i < 5; i++) pulse(1, 1'b0, tsList[i]);
    idle(1'b0);
    idle(1'b0);
    cmp("ovf.flag", 32'(oOvf), 1); cmp("ovf.drop", 32'(oDrop), 1);
    for (int j = 0; j < 4; j++) begin
      cmp($sformatf("drain%0d.valid", j), 32'(rd.oValid), 1);
      cmp($sformatf("drain%0d.ts", j), 32'(rd.oTs), 32'(tsList[j]));
      idle(1'b1);
    end
    cmp("drain.empty", 32'(rd.oValid), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cmp("clr.ovf", 32'(oOvf), 0); cmp("clr.drop", 32'(oDrop), 0);

    // Coarse counter wrap: rise at 250, fall at 4.
    for (int k = 0; k < 300; k++) begin
      if (cyc % 256 == 250) break;
      idle(1'b1);
    end
    pulse(10, 1'b1, tsv);
    idle(1'b0);
    cmp("wrap.ts", 32'(rd.oTs), 250); cmp("wrap.width", 32'(rd.oWidth), 10);
    cmp("wrap.sat", 32'(rd.oSat), 0);
    idle(1'b1);

    // Stray fall in IDLE, and a capture abandoned by dropping the enable.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);
    cmp("strayFall.valid", 32'(rd.oValid), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cmp("abort.busyOn", 32'(oBusy), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("abort.busyOff", 32'(oBusy), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);
    cmp("abort.valid", 32'(rd.oValid), 0);

    // Reset in the middle of operation with stored records and overflow set.
    for (int i = 0; i < 5; i++) pulse(3, 1'b0, tsv);
    idle(1'b0);
    cmp("preRst.valid", 32'(rd.oValid), 1); cmp("preRst.ovf", 32'(oOvf), 1);
    iRst_n = 1'b0;
    #1;
    checkOutput(zeroOut, "midRst");
    @(negedge iClk);
    iRst_n = 1'b1;
    modelReset();
    idle(1'b0);

    // A clear in the same cycle as a drop leaves one counted drop.
    for (int i = 0; i < 7; i++) pulse(1, 1'b0, tsv);
    cmp("preClr.drop", 32'(oDrop), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("clrDrop.ovf", 32'(oOvf), 1); cmp("clrDrop.drop", 32'(oDrop), 1);

    // The drop counter saturates at 255.
    for (int i = 0; i < 260; i++) pulse(1, 1'b0, tsv);
    idle(1'b0);
    cmp("dropSat", 32'(oDrop), 255);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) idle(1'b1);

    // Random traffic: short busy pulses first, then long sparse ones that saturate.
    for (int n = 0; n < 3000; n++) begin
      rEn    = ($urandom_range(0, 19) != 0);
      rRise  = (n < 1500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
      rFall  = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
      rClr   = ($urandom_range(0, 63) == 0);
      rReady = ($urandom_range(0, 2) != 0);
      applyStimulus(rEn, rRise, rFall, rClr, rReady);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
